pixel_write_scheduler: RTL

- Sits between the CPU's pixel-store path and the pixel writer.
- Buffers CPU pixel writes in a small FIFO.
- Holds all issue until the writer reports the screen clear is done, then issues exactly one write at a time using the writer's pixel_en / pixel_wr_done handshake.
- Provides occupancy/idle status for software sync and a sticky timeout error if the writer stops responding.

---
 rtl/pixel_write_scheduler_pkg.sv | 25 ++
 rtl/pixel_write_scheduler_if.sv | 29 ++
 rtl/pixel_write_scheduler_sync_fifo.sv | 66 ++++++
 rtl/pixel_write_scheduler.sv | 127 ++++++++++++
 4 files changed

// File: rtl/pixel_write_scheduler_pkg.sv
// Shared types and constants for the pixel write scheduler:
// FSM state encoding and the layout of a queued pixel entry.
package pixel_write_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LO = 2'd1,
    ST_WAIT_HI = 2'd2
  } sched_state_e;

  localparam int FIELD_W = 8;
  localparam int PIX_W   = 24;
  localparam int RGB_LSB = 16;
  localparam int X_LSB   = 8;
  localparam int Y_LSB   = 0;

  function automatic logic [PIX_W-1:0] pack_pixel(
    input logic [FIELD_W-1:0] rgb,
    input logic [FIELD_W-1:0] x,
    input logic [FIELD_W-1:0] y
  );
    return {rgb, x, y};
  endfunction

endpackage

// File: rtl/pixel_write_scheduler_if.sv
// CPU pixel-store bus and pixel-writer handshake grouped into one interface.
// The slave modport is the scheduler's view; master is the CPU/writer side.
interface pixel_write_scheduler_if;

  logic       cpu_pixel_valid;
  logic       cpu_pixel_ready;
  logic [7:0] cpu_pixel_rgb;
  logic [7:0] cpu_pixel_x;
  logic [7:0] cpu_pixel_y;
  logic       clear_screen_done;
  logic       pixel_wr_done;
  logic       pixel_en;
  logic [7:0] pixel_rgb;
  logic [7:0] pixel_x;
  logic [7:0] pixel_y;

  modport slave (
    input  cpu_pixel_valid, cpu_pixel_rgb, cpu_pixel_x, cpu_pixel_y,
    input  clear_screen_done, pixel_wr_done,
    output cpu_pixel_ready, pixel_en, pixel_rgb, pixel_x, pixel_y
  );

  modport master (
    output cpu_pixel_valid, cpu_pixel_rgb, cpu_pixel_x, cpu_pixel_y,
    output clear_screen_done, pixel_wr_done,
    input  cpu_pixel_ready, pixel_en, pixel_rgb, pixel_x, pixel_y
  );

endinterface

// File: rtl/pixel_write_scheduler_sync_fifo.sv
// Generic synchronous FIFO with registered storage and occupancy count.
// DEPTH must be a power of two so the AW-bit pointers wrap on their own.
module sync_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Entry storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign level = count_r;
  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == '0);

endmodule

// File: rtl/pixel_write_scheduler.sv
// Queues CPU pixel writes and issues them one at a time to the pixel writer
// once the screen clear is done, with a per-phase handshake timeout.
module pixel_write_scheduler
  import pixel_write_scheduler_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  pixel_write_scheduler_if.slave  bus,
  output logic [AW:0]             queue_level,
  output logic                    idle,
  output logic                    timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT);

  sched_state_e     state_r;
  sched_state_e     state_s;
  logic [TW-1:0]    timer_r;
  logic [TW-1:0]    timer_s;
  logic             issue_s;
  logic             expire_s;
  logic             push_s;
  logic [PIX_W-1:0] head_s;
  logic [AW:0]      fifo_level_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             pixel_en_r;
  logic [PIX_W-1:0] pixel_data_r;
  logic             timeout_err_r;

  assign push_s = bus.cpu_pixel_valid && !fifo_full_s;

  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (issue_s),
    .wdata (pack_pixel(bus.cpu_pixel_rgb, bus.cpu_pixel_x, bus.cpu_pixel_y)),
    .rdata (head_s),
    .level (fifo_level_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state, timer and issue decision
  always_comb begin
    state_s  = state_r;
    timer_s  = timer_r;
    issue_s  = 1'b0;
    expire_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s && bus.clear_screen_done && bus.pixel_wr_done) begin
          issue_s = 1'b1;
          timer_s = TIMER_LOAD;
          state_s = ST_WAIT_LO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT_LO: begin
        if (!bus.pixel_wr_done) begin
          timer_s = TIMER_LOAD;
          state_s = ST_WAIT_HI;
        end else if (timer_r == '0) begin
          expire_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          timer_s = timer_r - TW'(1);
        end
      end
      ST_WAIT_HI: begin
        if (bus.pixel_wr_done) begin
          state_s = ST_IDLE;
        end else if (timer_r == '0) begin
          expire_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          timer_s = timer_r - TW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        timer_s = '0;
      end
    endcase
  end

  // State, timer and registered writer-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      timer_r       <= '0;
      pixel_en_r    <= 1'b0;
      pixel_data_r  <= '0;
      timeout_err_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      timer_r       <= timer_s;
      pixel_en_r    <= issue_s;
      timeout_err_r <= timeout_err_r | expire_s;
      if (issue_s) begin
        pixel_data_r <= head_s;
      end
    end
  end

  assign bus.cpu_pixel_ready = !fifo_full_s;
  assign bus.pixel_en        = pixel_en_r;
  assign bus.pixel_rgb       = pixel_data_r[RGB_LSB +: FIELD_W];
  assign bus.pixel_x         = pixel_data_r[X_LSB +: FIELD_W];
  assign bus.pixel_y         = pixel_data_r[Y_LSB +: FIELD_W];

  assign queue_level = fifo_level_s;
  assign idle        = (fifo_level_s == '0) && (state_r == ST_IDLE);
  assign timeout_err = timeout_err_r;

endmodule
